// File: rtl/cache_data_array.sv
// rtl/cache_data_array.sv - N-way set-indexed cache data store with byte-enabled writes and burst line refill.
// Define CACHE_DATA_FWD_EN to forward same-edge word writes / line commits onto the read port.
module cache_data_array #(
    parameter int INDEX_WIDTH = 7,
    parameter int BLOCK_WIDTH = 128,
    parameter int WORD_WIDTH  = 32,
    parameter int NUM_WAYS    = 2,
    localparam int BEATS      = BLOCK_WIDTH / WORD_WIDTH,
    localparam int WAY_W      = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
    localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rd_en,
    input  logic [INDEX_WIDTH-1:0]          rd_index,
    output logic [NUM_WAYS*BLOCK_WIDTH-1:0] rd_data,
    output logic                            rd_valid,
    input  logic                            wr_en,
    output logic                            wr_ready,
    input  logic [INDEX_WIDTH-1:0]          wr_index,
    input  logic [WAY_W-1:0]                wr_way,
    input  logic [BEAT_W-1:0]               wr_word,
    input  logic [WORD_WIDTH/8-1:0]         wr_be,
    input  logic [WORD_WIDTH-1:0]           wr_data,
    input  logic                            fill_start,
    input  logic [INDEX_WIDTH-1:0]          fill_index,
    input  logic [WAY_W-1:0]                fill_way,
    input  logic                            fill_beat_valid,
    input  logic [WORD_WIDTH-1:0]           fill_beat_data,
    output logic                            busy,
    output logic                            fill_done
);
    localparam int SETS       = 2 ** INDEX_WIDTH;
    localparam int WORD_BYTES = WORD_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [BEAT_W-1:0]        cnt;
    logic [INDEX_WIDTH-1:0]   fill_idx_q;
    logic [WAY_W-1:0]         fill_way_q;
    logic [BLOCK_WIDTH-1:0]   line_buf;
    logic                     fill_accept;
    logic                     beat_take;
    logic                     beat_last;
    logic                     wr_fire;
    logic                     commit_en;
    logic [BLOCK_WIDTH-1:0]   wr_line;
    logic [NUM_WAYS*BLOCK_WIDTH-1:0] rd_next;

    logic [BLOCK_WIDTH-1:0] mem [NUM_WAYS][SETS];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        busy        = 1'b0;
        fill_done   = 1'b0;
        wr_ready    = 1'b1;
        fill_accept = 1'b0;
        beat_take   = 1'b0;
        beat_last   = (cnt == BEAT_W'(BEATS - 1));
        case (state)
            IDLE: begin
                if (fill_start) begin
                    fill_accept = 1'b1;
                    state_next  = FILL;
                end
            end
            FILL: begin
                busy = 1'b1;
                // Only the line being refilled is blocked; other set/way pairs stay writable.
                if (wr_index == fill_idx_q && wr_way == fill_way_q) begin
                    wr_ready = 1'b0;
                end
                if (fill_beat_valid) begin
                    beat_take = 1'b1;
                    if (beat_last) begin
                        state_next = COMMIT;
                    end
                end
            end
            COMMIT: begin
                busy       = 1'b1;
                fill_done  = 1'b1;
                wr_ready   = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (fill_accept) begin
            cnt <= '0;
        end else if (beat_take) begin
            cnt <= beat_last ? '0 : cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && fill_accept) begin
            fill_idx_q <= fill_index;
            fill_way_q <= fill_way;
            line_buf   <= '0;
        end else if (!rst && beat_take) begin
            line_buf[cnt*WORD_WIDTH +: WORD_WIDTH] <= fill_beat_data;
        end
    end

    assign wr_fire   = wr_en & wr_ready;
    assign commit_en = (state == COMMIT) & ~rst;

    always_comb begin
        wr_line = mem[wr_way][wr_index];
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (wr_be[b]) begin
                wr_line[wr_word*WORD_WIDTH + b*8 +: 8] = wr_data[b*8 +: 8];
            end
        end
    end

    // Commit and word write are exclusive: wr_ready is low throughout COMMIT.
    always_ff @(posedge clk) begin
        if (commit_en) begin
            mem[fill_way_q][fill_idx_q] <= line_buf;
        end else if (wr_fire) begin
            mem[wr_way][wr_index] <= wr_line;
        end
    end

    always_comb begin
        rd_next = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            rd_next[w*BLOCK_WIDTH +: BLOCK_WIDTH] = mem[w][rd_index];
`ifdef CACHE_DATA_FWD_EN
            if (wr_fire && wr_index == rd_index && wr_way == WAY_W'(w)) begin
                rd_next[w*BLOCK_WIDTH +: BLOCK_WIDTH] = wr_line;
            end
            if (commit_en && fill_idx_q == rd_index && fill_way_q == WAY_W'(w)) begin
                rd_next[w*BLOCK_WIDTH +: BLOCK_WIDTH] = line_buf;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= rd_next;
            end
        end
    end

endmodule

// File: tb/tb_cache_data_array.sv
// tb/tb_cache_data_array.sv - self-checking bench for cache_data_array against a byte-addressed model.
module tb_cache_data_array;
    localparam int IW    = 7;
    localparam int BW    = 128;
    localparam int WW    = 32;
    localparam int NW    = 2;
    localparam int BEATS = BW / WW;
    localparam int SETS  = 2 ** IW;
    localparam int LB    = BW / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              rd_en;
    logic [IW-1:0]     rd_index;
    logic [NW*BW-1:0]  rd_data;
    logic              rd_valid;
    logic              wr_en;
    logic              wr_ready;
    logic [IW-1:0]     wr_index;
    logic [0:0]        wr_way;
    logic [1:0]        wr_word;
    logic [3:0]        wr_be;
    logic [WW-1:0]     wr_data;
    logic              fill_start;
    logic [IW-1:0]     fill_index;
    logic [0:0]        fill_way;
    logic              fill_beat_valid;
    logic [WW-1:0]     fill_beat_data;
    logic              busy;
    logic              fill_done;

    cache_data_array #(
        .INDEX_WIDTH(IW), .BLOCK_WIDTH(BW), .WORD_WIDTH(WW), .NUM_WAYS(NW)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_en(rd_en), .rd_index(rd_index), .rd_data(rd_data), .rd_valid(rd_valid),
        .wr_en(wr_en), .wr_ready(wr_ready), .wr_index(wr_index), .wr_way(wr_way),
        .wr_word(wr_word), .wr_be(wr_be), .wr_data(wr_data),
        .fill_start(fill_start), .fill_index(fill_index), .fill_way(fill_way),
        .fill_beat_valid(fill_beat_valid), .fill_beat_data(fill_beat_data),
        .busy(busy), .fill_done(fill_done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference store: plain byte array, byte b of a line is bits [b*8 +: 8].
    logic [7:0] mb [NW][SETS][LB];

    typedef struct {
        bit          wr;
        int          way_w;
        int          word_w;
        logic [3:0]  be;
        logic [31:0] data;
        int          way_r;
        int          word_r;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [10];

    function automatic logic [NW*BW-1:0] mset(int s);
        logic [NW*BW-1:0] r;
        for (int w = 0; w < NW; w++)
            for (int b = 0; b < LB; b++)
                r[(w*LB + b)*8 +: 8] = mb[w][s][b];
        return r;
    endfunction

    function automatic logic [NW*BW-1:0] apply_word(logic [NW*BW-1:0] cur, int w, int wd,
                                                    logic [3:0] be, logic [31:0] d);
        logic [NW*BW-1:0] r;
        r = cur;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[(w*LB + wd*4 + i)*8 +: 8] = d[i*8 +: 8];
        return r;
    endfunction

    task automatic mwrite(int w, int s, int wd, logic [3:0] be, logic [31:0] d);
        for (int i = 0; i < 4; i++)
            if (be[i]) mb[w][s][wd*4 + i] = d[i*8 +: 8];
    endtask

    task automatic mfill(int w, int s, logic [BW-1:0] line);
        for (int b = 0; b < LB; b++) mb[w][s][b] = line[b*8 +: 8];
    endtask

    function automatic logic [BW-1:0] init_line(int w, int s);
        logic [BW-1:0] l;
        for (int k = 0; k < BEATS; k++)
            l[k*32 +: 32] = 32'hC0DE0000 | 32'(w << 12) | 32'(s << 4) | 32'(k);
        return l;
    endfunction

    function automatic logic [BW-1:0] rand_line();
        logic [BW-1:0] l;
        for (int k = 0; k < BEATS; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, logic [NW*BW-1:0] act, logic [NW*BW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_fill(int s, int w, logic [BW-1:0] line, int gap_after, bit noise, bit rd_commit);
        logic [NW*BW-1:0] exp;
        fill_start      = 1'b1;
        fill_index      = IW'(s);
        fill_way        = 1'(w);
        fill_beat_valid = noise;
        fill_beat_data  = 32'hBAD0BAD0;
        tick();
        fill_start = 1'b0;
        for (int k = 0; k < BEATS; k++) begin
            chk("busy_in_fill", busy, 1);
            chk("fill_done_early", fill_done, 0);
            fill_beat_valid = 1'b1;
            fill_beat_data  = line[k*32 +: 32];
            tick();
            if (k == gap_after && k < BEATS - 1) begin
                fill_beat_valid = 1'b0;
                tick();
            end
        end
        fill_beat_valid = 1'b0;
        chk("fill_done_commit", fill_done, 1);
        chk("wr_ready_commit", wr_ready, 0);
        exp = mset(s);
`ifdef CACHE_DATA_FWD_EN
        exp[w*BW +: BW] = line;
`endif
        if (rd_commit) begin
            rd_en    = 1'b1;
            rd_index = IW'(s);
        end
        mfill(w, s, line);
        tick();
        rd_en = 1'b0;
        chk("fill_done_pulse", fill_done, 0);
        chk("busy_after_fill", busy, 0);
        if (rd_commit) chk("rd_during_commit", rd_data, exp);
    endtask

    task automatic do_read(int s, output logic [NW*BW-1:0] d);
        rd_en    = 1'b1;
        rd_index = IW'(s);
        tick();
        rd_en = 1'b0;
        chk("rd_valid", rd_valid, 1);
        d = rd_data;
    endtask

    task automatic check_set(int s);
        logic [NW*BW-1:0] d;
        do_read(s, d);
        chk("rd_set", d, mset(s));
    endtask

    task automatic rw(bit rd, int rs, bit wr, int ws, int w, int wd, logic [3:0] be, logic [31:0] d);
        logic [NW*BW-1:0] exp;
        exp = mset(rs);
`ifdef CACHE_DATA_FWD_EN
        if (rd && wr && rs == ws) exp = apply_word(exp, w, wd, be, d);
`endif
        rd_en    = rd;
        rd_index = IW'(rs);
        wr_en    = wr;
        wr_index = IW'(ws);
        wr_way   = 1'(w);
        wr_word  = 2'(wd);
        wr_be    = be;
        wr_data  = d;
        #1;
        if (wr) begin
            chk("wr_ready_idle", wr_ready, 1);
            mwrite(w, ws, wd, be, d);
        end
        tick();
        rd_en = 1'b0;
        wr_en = 1'b0;
        chk("rd_valid_rw", rd_valid, rd);
        if (rd) chk("rd_data_rw", rd_data, exp);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [NW*BW-1:0] d;
        logic [BW-1:0]    l7;
        logic [BW-1:0]    l9;

        rst = 1'b1; rd_en = 1'b0; rd_index = '0; wr_en = 1'b0; wr_index = '0; wr_way = '0;
        wr_word = '0; wr_be = '0; wr_data = '0; fill_start = 1'b0; fill_index = '0;
        fill_way = '0; fill_beat_valid = 1'b0; fill_beat_data = '0;
        tick();
        tick();
        rst = 1'b0;
        chk("reset_rd_valid", rd_valid, 0);
        chk("reset_rd_data", rd_data, 0);
        chk("reset_busy", busy, 0);
        chk("reset_fill_done", fill_done, 0);
        chk("reset_wr_ready", wr_ready, 1);

        rd_en = 1'b1; rd_index = 7'd5;
        tick();
        rd_en = 1'b0;
        chk("rd5_valid", rd_valid, 1);
        tick();
        chk("rd5_valid_drop", rd_valid, 0);

        // Bring every line to a known value so the model is complete.
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < NW; w++)
                do_fill(s, w, init_line(w, s), -1, 1'b0, 1'b0);

        do_fill(3, 1, 128'h44444444_33333333_22222222_11111111, 1, 1'b1, 1'b0);
        check_set(3);

        tbl[0] = '{1'b0, 0, 0, 4'h0, 32'h0,        1, 0, 32'h11111111};
        tbl[1] = '{1'b0, 0, 0, 4'h0, 32'h0,        1, 1, 32'h22222222};
        tbl[2] = '{1'b0, 0, 0, 4'h0, 32'h0,        1, 2, 32'h33333333};
        tbl[3] = '{1'b0, 0, 0, 4'h0, 32'h0,        1, 3, 32'h44444444};
        tbl[4] = '{1'b1, 1, 2, 4'b0101, 32'hAABBCCDD, 1, 2, 32'h33BB33DD};
        tbl[5] = '{1'b0, 0, 0, 4'h0, 32'h0,        0, 2, 32'hC0DE0032};
        tbl[6] = '{1'b1, 1, 0, 4'b0000, 32'hFFFFFFFF, 1, 0, 32'h11111111};
        tbl[7] = '{1'b1, 0, 3, 4'b1111, 32'h12345678, 0, 3, 32'h12345678};
        tbl[8] = '{1'b0, 0, 0, 4'h0, 32'h0,        1, 3, 32'h44444444};
        tbl[9] = '{1'b1, 1, 1, 4'b1000, 32'hDEADBEEF, 1, 1, 32'hDE222222};
        for (int i = 0; i < 10; i++) begin
            if (tbl[i].wr)
                rw(1'b0, 0, 1'b1, 3, tbl[i].way_w, tbl[i].word_w, tbl[i].be, tbl[i].data);
            do_read(3, d);
            chk("table_word", 256'(d[(tbl[i].way_r*BW + tbl[i].word_r*32) +: 32]), 256'(tbl[i].exp));
        end

        // Refill of 7/0 with a blocked and an allowed concurrent word write.
        l7 = 128'h70000004_70000003_70000002_70000001;
        fill_start = 1'b1; fill_index = 7'd7; fill_way = 1'b0;
        tick();
        fill_start = 1'b1; fill_index = 7'd8; fill_way = 1'b1;
        wr_en = 1'b1; wr_index = 7'd7; wr_way = 1'b0; wr_word = 2'd0; wr_be = 4'hF;
        wr_data = 32'h99999999;
        #1;
        chk("wr_ready_same_line", wr_ready, 0);
        wr_way = 1'b1;
        #1;
        chk("wr_ready_other_way", wr_ready, 1);
        mwrite(1, 7, 0, 4'hF, 32'h99999999);
        fill_beat_valid = 1'b1; fill_beat_data = l7[31:0];
        tick();
        wr_en = 1'b0; fill_start = 1'b0;
        for (int k = 1; k < BEATS; k++) begin
            chk("fill7_no_done", fill_done, 0);
            fill_beat_data = l7[k*32 +: 32];
            tick();
        end
        fill_beat_valid = 1'b0;
        wr_en = 1'b1; wr_index = 7'd20; wr_way = 1'b1; wr_word = 2'd1; wr_data = 32'h55555555;
        #1;
        chk("wr_ready_commit_other", wr_ready, 0);
        chk("fill7_done", fill_done, 1);
        mfill(0, 7, l7);
        tick();
        wr_en = 1'b0;
        check_set(7);
        check_set(8);
        check_set(20);

        // Reset in the middle of a refill discards the partial line.
        l9 = rand_line();
        fill_start = 1'b1; fill_index = 7'd9; fill_way = 1'b1;
        tick();
        fill_start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            fill_beat_valid = 1'b1; fill_beat_data = l9[k*32 +: 32];
            tick();
        end
        fill_beat_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_done", fill_done, 0);
        chk("rst_mid_rd_data", rd_data, 0);
        tick();
        chk("rst_mid_busy_hold", busy, 0);
        check_set(9);
        do_fill(10, 0, rand_line(), -1, 1'b0, 1'b0);
        check_set(10);
        check_set(9);

        rw(1'b1, 4, 1'b1, 4, 1, 1, 4'b0110, 32'hCAFEF00D);
        do_fill(4, 0, rand_line(), 2, 1'b0, 1'b1);
        check_set(4);

        for (int it = 0; it < 300; it++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r < 6)
                rw(1'($urandom_range(0, 1)), $urandom_range(0, 7), 1'($urandom_range(0, 4) != 0),
                   $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 3),
                   4'($urandom_range(0, 15)), $urandom);
            else if (r < 8)
                do_fill($urandom_range(0, 7), $urandom_range(0, 1), rand_line(),
                        $urandom_range(0, 3) - 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            else
                check_set($urandom_range(0, 7));
        end
        for (int s = 0; s < 8; s++) check_set(s);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
